// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA loopback controller.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LINE_BYTES = 64;
    localparam int LINE_SHIFT = $clog2(LINE_BYTES);

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_SIZE_WIDTH = 17;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/dma_loopback_ctrl_if.sv
// Read-request, read-response and write channels between the controller and memory.
interface dma_loopback_ctrl_if
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  rd_req_en;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_full;
    logic                  rd_rsp_valid;
    logic [DATA_WIDTH-1:0] rd_rsp_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;

    modport master (
        output rd_req_en, rd_req_addr, wr_en, wr_req_addr, wr_data,
        input  rd_req_full, rd_rsp_valid, rd_rsp_data, wr_full
    );

    modport slave (
        input  rd_req_en, rd_req_addr, wr_en, wr_req_addr, wr_data,
        output rd_req_full, rd_rsp_valid, rd_rsp_data, wr_full
    );

endinterface

// File: rtl/dma_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the oldest entry while not empty.
module dma_fifo
    import dma_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dma_loopback_ctrl.sv
// Copies `size` cache lines from a read base to a write base through a credit-limited line buffer.
module dma_loopback_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  done,
    dma_loopback_ctrl_if.master   mem
);

    localparam int CNT_W = SIZE_WIDTH + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
    logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
    logic [CNT_W-1:0]      size_q, size_d;
    logic [CNT_W-1:0]      reads_q, reads_d;
    logic [CNT_W-1:0]      writes_q, writes_d;
    logic [LVL_W-1:0]      outstanding_q, outstanding_d;
    logic                  done_q, done_d;

    logic                  busy;
    logic                  rsp_accept;
    logic                  credit_ok;
    logic [LVL_W:0]        in_flight;
    logic                  fifo_full, fifo_empty;
    logic [LVL_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign busy = (state_q == ST_BUSY);

    // Lines requested but not yet written may never exceed the buffer depth.
    assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok = !fifo_full && (in_flight < (LVL_W+1)'(FIFO_DEPTH));

    assign mem.rd_req_en   = busy && (reads_q < size_q) && !mem.rd_req_full && credit_ok;
    assign mem.rd_req_addr = rd_base_q + (ADDR_WIDTH'(reads_q) << LINE_SHIFT);

    // Responses are only meaningful against a live request; anything else is stale.
    assign rsp_accept = busy && mem.rd_rsp_valid && (outstanding_q != '0);

    assign mem.wr_en       = !fifo_empty && !mem.wr_full;
    assign mem.wr_req_addr = wr_base_q + (ADDR_WIDTH'(writes_q) << LINE_SHIFT);
    assign mem.wr_data     = fifo_head;

    assign done = done_q;

    dma_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_accept),
        .din   (mem.rd_rsp_data),
        .pop   (mem.wr_en),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        rd_base_d     = rd_base_q;
        wr_base_d     = wr_base_q;
        size_d        = size_q;
        reads_d       = reads_q;
        writes_d      = writes_q;
        outstanding_d = outstanding_q;
        done_d        = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_d       = ST_BUSY;
                    rd_base_d     = rd_addr;
                    wr_base_d     = wr_addr;
                    size_d        = CNT_W'(size);
                    reads_d       = '0;
                    writes_d      = '0;
                    outstanding_d = '0;
                    done_d        = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem.rd_req_en) reads_d  = reads_q + 1'b1;
                if (mem.wr_en)     writes_d = writes_q + 1'b1;
                case ({mem.rd_req_en, rsp_accept})
                    2'b10:   outstanding_d = outstanding_q + 1'b1;
                    2'b01:   outstanding_d = outstanding_q - 1'b1;
                    default: outstanding_d = outstanding_q;
                endcase
                if (writes_q == size_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_base_q     <= '0;
            wr_base_q     <= '0;
            size_q        <= '0;
            reads_q       <= '0;
            writes_q      <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_base_q     <= rd_base_d;
            wr_base_q     <= wr_base_d;
            size_q        <= size_d;
            reads_q       <= reads_d;
            writes_q      <= writes_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_dma_loopback_ctrl.sv
// Scoreboard bench: expected read/write streams are derived from each go; a monitor compares live traffic.
module tb_dma_loopback_ctrl;

    localparam int AW    = 64;
    localparam int SW    = 17;
    localparam int DW    = 512;
    localparam int DEPTH = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] size;
    logic          done;

    dma_loopback_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    dma_loopback_ctrl #(
        .ADDR_WIDTH (AW),
        .SIZE_WIDTH (SW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .size    (size),
        .done    (done),
        .mem     (mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [AW-1:0] exp_rd[$];
    wr_t           exp_wr[$];
    rsp_t          pend[$];
    int            reads_seen  = 0;
    int            writes_seen = 0;
    int            rd_bp_pct   = 0;
    int            wr_bp_pct   = 0;
    int            dly_max     = 0;
    int            wr_hold     = 0;
    int            go_cyc      = 0;
    int            lat;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Memory contents: each line is a fixed function of its byte address.
    function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 64; k++)
            d[k*64 +: 64] = a ^ (64'h9E37_79B9_7F4A_7C15 * 64'(k + 1)) ^ {32'(k), 32'hA5A5_0000};
        return d;
    endfunction

    // Memory model: random backpressure, in-order responses after a random delay.
    initial begin
        int last_due = 0;
        mem.rd_req_full  = 1'b0;
        mem.wr_full      = 1'b0;
        mem.rd_rsp_valid = 1'b0;
        mem.rd_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem.rd_req_full = (rd_bp_pct != 0) && ($urandom_range(0, 99) < rd_bp_pct);
            if (wr_hold > 0) begin
                mem.wr_full = 1'b1;
                wr_hold--;
            end else begin
                mem.wr_full = (wr_bp_pct != 0) && ($urandom_range(0, 99) < wr_bp_pct);
            end
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                rsp_t r;
                r = pend.pop_front();
                mem.rd_rsp_valid = 1'b1;
                mem.rd_rsp_data  = r.data;
            end else begin
                mem.rd_rsp_valid = 1'b0;
                mem.rd_rsp_data  = '0;
            end
            #1;
            if (mem.rd_req_en && !rst) begin
                int due;
                due = cyc + 1 + $urandom_range(0, dly_max);
                if (due < last_due) due = last_due;
                last_due = due;
                pend.push_back('{due, line_data(mem.rd_req_addr)});
            end
        end
    end

    // Monitor: every accepted request is popped against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem.rd_req_en) begin
                    check("rd_credit", 1'(reads_seen - writes_seen < DEPTH), 1'b1);
                    if (exp_rd.size() == 0) check("rd_unexpected", mem.rd_req_en, 1'b0);
                    else                    check("rd_addr", mem.rd_req_addr, exp_rd.pop_front());
                    reads_seen++;
                end
                if (mem.wr_en) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", mem.wr_en, 1'b0);
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        check("wr_addr", mem.wr_req_addr, w.addr);
                        check("wr_data", mem.wr_data, w.data);
                    end
                    writes_seen++;
                end
            end
        end
    end

    task automatic set_env(input int rbp, input int wbp, input int dmax);
        rd_bp_pct = rbp;
        wr_bp_pct = wbp;
        dly_max   = dmax;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        reads_seen  = 0;
        writes_seen = 0;
        #3;
        check("rst_done", done, 1'b0);
        check("rst_rd_req_en", mem.rd_req_en, 1'b0);
        check("rst_wr_en", mem.wr_en, 1'b0);
    endtask

    task automatic start_xfer(input logic [AW-1:0] r, input logic [AW-1:0] w, input int n);
        reads_seen  = 0;
        writes_seen = 0;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(r + 64'(i) * 64'd64);
            exp_wr.push_back('{w + 64'(i) * 64'd64, line_data(r + 64'(i) * 64'd64)});
        end
        @(negedge clk);
        go      = 1'b1;
        rd_addr = r;
        wr_addr = w;
        size    = SW'(n);
        go_cyc  = cyc;
        @(negedge clk);
        go      = 1'b0;
        rd_addr = {$urandom, $urandom};
        wr_addr = {$urandom, $urandom};
        size    = SW'($urandom);
    endtask

    task automatic wait_done(input int budget, output int latency);
        latency = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (done) begin
                latency = cyc - go_cyc;
                break;
            end
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic finish_xfer(input int n);
        check("rd_left", 32'(exp_rd.size()), 32'd0);
        check("wr_left", 32'(exp_wr.size()), 32'd0);
        check("rd_count", 32'(reads_seen), 32'(n));
        check("wr_count", 32'(writes_seen), 32'(n));
        @(negedge clk);
        #3;
        check("done_held", done, 1'b1);
    endtask

    initial begin
        go      = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        size    = '0;
        rst     = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);

        // Ideal channels, four lines.
        set_env(0, 0, 0);
        start_xfer(64'h1000, 64'h8000, 4);
        wait_done(200, lat);
        finish_xfer(4);

        // Zero-length transfer completes within two cycles with no traffic.
        start_xfer(64'h2000, 64'h9000, 0);
        wait_done(20, lat);
        check("zero_latency", 1'(lat >= 0 && lat <= 2), 1'b1);
        finish_xfer(0);

        // Write channel stalled: reads stop at exactly the buffer depth.
        wr_hold = 100;
        start_xfer(64'h20000, 64'h40000, 64);
        repeat (90) @(negedge clk);
        #3;
        check("stall_reads", 32'(reads_seen), 32'(DEPTH));
        check("stall_writes", 32'(writes_seen), 32'd0);
        wait_done(2000, lat);
        finish_xfer(64);

        // Random backpressure and latency; a go while busy must be ignored.
        set_env(30, 30, 20);
        start_xfer({$urandom, $urandom}, {$urandom, $urandom}, 100);
        repeat (20) @(negedge clk);
        go      = 1'b1;
        rd_addr = 64'hDEAD_0000;
        size    = SW'(5);
        @(negedge clk);
        go = 1'b0;
        wait_done(5000, lat);
        finish_xfer(100);

        // Read address wraps past the top of the address space.
        set_env(0, 0, 0);
        start_xfer(64'hFFFF_FFFF_FFFF_FFC0, 64'h100, 2);
        wait_done(200, lat);
        finish_xfer(2);

        // Abort mid-transfer; stale responses drain while idle, then a short transfer.
        set_env(0, 20, 8);
        start_xfer(64'h5000, 64'h9000, 32);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (writes_seen >= 10) break;
        end
        check("mid_reached", 1'(writes_seen >= 10), 1'b1);
        do_reset();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pend.size() == 0) break;
        end
        check("stale_drained", 32'(pend.size()), 32'd0);
        repeat (3) @(negedge clk);
        set_env(0, 0, 0);
        start_xfer(64'h7000, 64'hA000, 3);
        wait_done(200, lat);
        finish_xfer(3);

        // A few fully random transfers.
        for (int t = 0; t < 3; t++) begin
            int n;
            n = $urandom_range(1, 40);
            set_env($urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 20));
            start_xfer({$urandom, $urandom}, {$urandom, $urandom}, n);
            wait_done(5000, lat);
            finish_xfer(n);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_loopback_ctrl.md
DMA_LOOPBACK_CTRL -- requirements
Module: dma_loopback_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte-address width of read and write addresses.
REQ-002 SHALL have parameter SIZE_WIDTH, default 17, width of the cache-line count.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, cache-line width in bits.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, line buffer depth (power of 2, >=2).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: go in 1 start pulse; rd_addr in ADDR_WIDTH source byte address; wr_addr in ADDR_WIDTH destination byte address; size in SIZE_WIDTH line count; done out 1 transfer complete.
REQ-007 SHALL have ports: rd_req_en out 1 read request; rd_req_addr out ADDR_WIDTH request address; rd_req_full in 1 read channel cannot accept.
REQ-008 SHALL have ports: rd_rsp_valid in 1 read data valid; rd_rsp_data in DATA_WIDTH read data (responses in request order).
REQ-009 SHALL have ports: wr_en out 1 write request; wr_req_addr out ADDR_WIDTH write address; wr_data out DATA_WIDTH write data; wr_full in 1 write channel cannot accept.

Function
REQ-010 SHALL implement states IDLE, BUSY, DONE.
REQ-011 IDLE/DONE + go=1 SHALL latch rd_addr, wr_addr and size, clear counters, clear done, enter BUSY next cycle.
REQ-012 go while BUSY SHALL be ignored; latched values SHALL be unchanged.
REQ-013 go with size=0 SHALL pass through BUSY for one cycle, then enter DONE with no requests issued.
REQ-014 In BUSY, rd_req_en SHALL be 1 iff reads_issued < size, rd_req_full=0, and (outstanding reads + FIFO count) < FIFO_DEPTH.
REQ-015 Each issued read SHALL use address base + 64*reads_issued, wrapping modulo 2**ADDR_WIDTH.
REQ-016 Each rd_rsp_valid=1 cycle SHALL push rd_rsp_data into the FIFO and decrement the outstanding count in the same cycle.
REQ-017 Credit accounting (REQ-014) SHALL guarantee the FIFO never overflows.
REQ-018 A simultaneous issue and response SHALL leave the outstanding count unchanged.
REQ-019 wr_en SHALL be 1 iff the FIFO is non-empty and wr_full=0.
REQ-020 wr_data SHALL equal the FIFO head; wr_req_addr SHALL equal wr base + 64*writes_issued.
REQ-021 A FIFO pop SHALL occur on every wr_en cycle.
REQ-022 FIFO push and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full or empty.
REQ-023 rd_req_en and wr_en SHALL be combinational from registered state, with zero-cycle acceptance: an asserted request counts as issued.
REQ-024 When writes_issued == size, the block SHALL enter DONE the next cycle; done SHALL be 1 in DONE only, held until the next accepted go.
REQ-025 Read-to-write latency SHALL be 1 cycle: data pushed in cycle N SHALL be eligible for wr_en in cycle N+1.
REQ-026 Counters SHALL be SIZE_WIDTH+1 bits wide so that size = 2**SIZE_WIDTH-1 completes without overflow.

Reset
REQ-027 rst=1 on a clk edge SHALL force IDLE, zero all counters and latched values, and empty the FIFO.
REQ-028 After reset, done, rd_req_en and wr_en SHALL be 0, and no request SHALL issue until the next go.
REQ-029 Reset mid-transfer SHALL abort immediately; responses arriving after reset SHALL be discarded.

Structure
REQ-030 A shared package dma_pkg SHALL hold the state enum type, the cache-line byte constant (64), and the default parameter values.
REQ-031 The line buffer SHALL be one sub-module, dma_fifo: a show-ahead synchronous FIFO with full, empty and count outputs, parameterized by width and depth.
REQ-032 The control FSM, address generators and credit counter SHALL reside in dma_loopback_ctrl.

Verification
REQ-033 Scenario: reset, then go with rd_addr=0x1000, wr_addr=0x8000, size=4, ideal channels -> reads at 0x1000/0x1040/0x1080/0x10C0; writes at 0x8000..0x80C0 with identical data; done=1.
REQ-034 Scenario: size=0 -> no rd_req_en or wr_en; done=1 within 2 cycles of go.
REQ-035 Scenario: size=64, wr_full held high for 100 cycles -> at most FIFO_DEPTH reads outstanding+buffered, no overflow, all 64 lines written in order.
REQ-036 Scenario: random rd_req_full/wr_full backpressure with response delay 0-20 cycles, size=100 -> write data and address sequence match the reads exactly.
REQ-037 Scenario: rd_addr=2**64-64, size=2 -> second read address is 0x0.
REQ-038 Scenario: rst asserted mid-transfer at line 10 of 32, then new go with size=3 -> only 3 writes; done=1; no stale data.
